trade_order_ctrl: RTL and testbench

Sequences the trading logic unit's buy_signal/sell_signal output into discrete orders for the downstream order gateway. Implements:
- a position-limit check, so net position never exceeds MAX_POS in either direction;
- an issue state with a valid/ready handshake to the gateway;
- a post-trade cooldown;
- an external halt (kill-switch).
Sits between the TLU decision stage and the order-gateway interface.

---
 rtl/tlu_ctrl_pkg.sv | 15 +
 rtl/ord_timer.sv | 28 ++
 rtl/trade_order_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_trade_order_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_ctrl_pkg.sv
// Shared types for the trade order controller.
// State encoding and order-side constants.
package tlu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOLDOWN,
        HALT
    } ord_state_t;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

endpackage

// File: rtl/ord_timer.sv
// Loadable down-counter with a zero flag.
// Shared by the cooldown and the optional issue timeout.
module ord_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trade_order_ctrl.sv
// Turns TLU buy/sell decisions into gateway orders with position limit,
// cooldown and kill-switch. Optional issue timeout: ORD_TIMEOUT_EN.
module trade_order_ctrl
    import tlu_ctrl_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int POS_W        = 8,
    parameter int ORD_QTY      = 1,
    parameter int MAX_POS      = 16,
    parameter int COOLDOWN_CYC = 4,
    parameter int TIMEOUT_CYC  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sig_valid,
    input  logic                    buy_signal,
    input  logic                    sell_signal,
    input  logic [data_width-1:0]   price,
    input  logic                    halt,
    output logic                    ord_valid,
    input  logic                    ord_ready,
    output logic                    ord_side,
    output logic [data_width-1:0]   ord_price,
    output logic [POS_W-1:0]        ord_qty,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
    output logic                    reject,
    output logic                    drop,
    output logic                    timeout
);

    localparam int MAXC = (COOLDOWN_CYC > TIMEOUT_CYC) ?
                          COOLDOWN_CYC : TIMEOUT_CYC;
    localparam int TW = $clog2(MAXC) + 1;
    localparam int CD_INT = (COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0;
    localparam logic [TW-1:0] CD_LOAD = TW'(CD_INT);
`ifdef ORD_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);
`endif

    // Limit arithmetic is one bit wider so the check itself cannot wrap.
    localparam logic signed [POS_W:0]   QTY_X = (POS_W+1)'(ORD_QTY);
    localparam logic signed [POS_W:0]   MAX_X = (POS_W+1)'(MAX_POS);
    localparam logic signed [POS_W-1:0] QTY_P = POS_W'(ORD_QTY);

    ord_state_t state;

    logic signed [POS_W:0] pos_x;
    logic buy_only;
    logic sell_only;
    logic over_long;
    logic over_short;
    logic accept;
    logic hs;

    logic          tmr_load;
    logic          tmr_dec;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    assign pos_x      = {position[POS_W-1], position};
    assign buy_only   = buy_signal & ~sell_signal;
    assign sell_only  = sell_signal & ~buy_signal;
    assign over_long  = (pos_x + QTY_X) > MAX_X;
    assign over_short = (pos_x - QTY_X) < -MAX_X;
    assign accept     = sig_valid &
                        ((buy_only & ~over_long) |
                         (sell_only & ~over_short));
    assign hs         = ord_valid & ord_ready;
    assign ord_qty    = QTY_P;

    ord_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = CD_LOAD;
        tmr_dec  = 1'b0;
        if (!halt) begin
            unique case (state)
                IDLE: begin
`ifdef ORD_TIMEOUT_EN
                    if (accept) begin
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                    end
`endif
                end
                ISSUE: begin
                    if (hs) begin
                        tmr_load = 1'b1;
                    end
`ifdef ORD_TIMEOUT_EN
                    else if (tmr_zero) begin
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
                COOLDOWN: tmr_dec = 1'b1;
                HALT: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ord_valid <= 1'b0;
            ord_side  <= 1'b0;
            ord_price <= '0;
            position  <= '0;
            busy      <= 1'b0;
            reject    <= 1'b0;
            drop      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            reject  <= 1'b0;
            drop    <= 1'b0;
            timeout <= 1'b0;
            if (sig_valid && state != IDLE) begin
                drop <= 1'b1;
            end
            if (halt) begin
                state     <= HALT;
                ord_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            state     <= ISSUE;
                            ord_valid <= 1'b1;
                            ord_side  <= buy_only ? SIDE_BUY : SIDE_SELL;
                            ord_price <= price;
                            busy      <= 1'b1;
                        end else if (sig_valid && (buy_only || sell_only)) begin
                            reject <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (hs) begin
                            position  <= (ord_side == SIDE_BUY) ?
                                         position + QTY_P :
                                         position - QTY_P;
                            ord_valid <= 1'b0;
                            state     <= (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
                            busy      <= (COOLDOWN_CYC != 0);
                        end
`ifdef ORD_TIMEOUT_EN
                        else if (tmr_zero) begin
                            ord_valid <= 1'b0;
                            timeout   <= 1'b1;
                            state     <= (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
                            busy      <= (COOLDOWN_CYC != 0);
                        end
`endif
                    end
                    COOLDOWN: begin
                        if (tmr_zero) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    HALT: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Self-checking bench for trade_order_ctrl: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_trade_order_ctrl;

    localparam int DW   = 8;
    localparam int PW   = 8;
    localparam int QTY  = 1;
    localparam int MAXP = 16;
    localparam int COOL = 4;
    localparam int TO   = 32;

    logic clk = 1'b0;
    logic rst;
    logic sig_valid, buy_signal, sell_signal, halt, ord_ready;
    logic [DW-1:0] price;
    logic ord_valid, ord_side, busy, reject, drop, timeout;
    logic [DW-1:0] ord_price;
    logic [PW-1:0] ord_qty;
    logic signed [PW-1:0] position;

    int vectors = 0;
    int errors  = 0;
    int exp_pos = 0;

    always #5 clk = ~clk;

    trade_order_ctrl #(
        .data_width   (DW),
        .POS_W        (PW),
        .ORD_QTY      (QTY),
        .MAX_POS      (MAXP),
        .COOLDOWN_CYC (COOL),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_valid   (sig_valid),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .price       (price),
        .halt        (halt),
        .ord_valid   (ord_valid),
        .ord_ready   (ord_ready),
        .ord_side    (ord_side),
        .ord_price   (ord_price),
        .ord_qty     (ord_qty),
        .position    (position),
        .busy        (busy),
        .reject      (reject),
        .drop        (drop),
        .timeout     (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decide(input logic b, input logic s, input logic [DW-1:0] p);
        sig_valid   = 1'b1;
        buy_signal  = b;
        sell_signal = s;
        price       = p;
        tick();
        sig_valid   = 1'b0;
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sig_valid = 0; buy_signal = 0; sell_signal = 0;
        halt = 0; ord_ready = 0; price = '0;
        #12;
        vectors++;
        if ({ord_valid, ord_side, ord_price, position, busy, reject, drop, timeout}
            !== '0) begin
            errors++;
            $display("FAIL reset outputs v=%b s=%b p=%0d pos=%0d b=%b r=%b d=%b t=%b",
                     ord_valid, ord_side, ord_price, position, busy, reject,
                     drop, timeout);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (ord_qty !== PW'(QTY) || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset qty=%0d busy=%b required %0d/0",
                     ord_qty, busy, QTY);
        end
    endtask

    task automatic test_basic_buy();
        int n = 0;
        ord_ready = 1'b1;
        decide(1'b1, 1'b0, 8'd50);
        vectors++;
        if ({ord_valid, ord_side, ord_price, busy} !== {1'b1, 1'b1, 8'd50, 1'b1}) begin
            errors++;
            $display("FAIL basic_issue v=%b s=%b p=%0d b=%b required 1/1/50/1",
                     ord_valid, ord_side, ord_price, busy);
        end
        tick();
        exp_pos += QTY;
        vectors++;
        if (ord_valid !== 1'b0 || position !== exp_pos[PW-1:0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake v=%b pos=%0d b=%b required 0/%0d/1",
                     ord_valid, position, busy, exp_pos);
        end
        while (busy && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n != COOL) begin
            errors++;
            $display("FAIL basic_cooldown cycles=%0d required %0d", n, COOL);
        end
    endtask

    task automatic test_backpressure();
        ord_ready = 1'b0;
        decide(1'b0, 1'b1, 8'd77);
        for (int i = 0; i < 10; i++) begin
            sig_valid   = (i % 2 == 0);
            sell_signal = 1'b1;
            price       = 8'($urandom);
            tick();
            vectors++;
            if ({ord_valid, ord_side, ord_price} !== {1'b1, 1'b0, 8'd77} ||
                position !== exp_pos[PW-1:0] || drop !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL backpressure i=%0d v=%b s=%b p=%0d pos=%0d drop=%b",
                         i, ord_valid, ord_side, ord_price, position, drop);
            end
        end
        sig_valid = 1'b0;
        sell_signal = 1'b0;
        ord_ready = 1'b1;
        tick();
        exp_pos -= QTY;
        vectors++;
        if (position !== exp_pos[PW-1:0] || ord_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept pos=%0d v=%b required %0d/0",
                     position, ord_valid, exp_pos);
        end
        wait_idle();
    endtask

    task automatic test_limit();
        int guard = 0;
        ord_ready = 1'b1;
        while (exp_pos < MAXP && guard < 40) begin
            decide(1'b1, 1'b0, 8'(guard));
            tick();
            exp_pos += QTY;
            wait_idle();
            guard++;
        end
        vectors++;
        if (position !== 8'sd16) begin
            errors++;
            $display("FAIL limit_fill pos=%0d required 16", position);
        end
        decide(1'b1, 1'b0, 8'd9);
        vectors++;
        if ({reject, ord_valid, busy} !== 3'b100 || position !== 8'sd16) begin
            errors++;
            $display("FAIL limit_reject r=%b v=%b b=%b pos=%0d required 1/0/0/16",
                     reject, ord_valid, busy, position);
        end
        tick();
        vectors++;
        if (reject !== 1'b0) begin
            errors++;
            $display("FAIL limit_pulse reject=%b required 0", reject);
        end
        decide(1'b0, 1'b1, 8'd9);
        vectors++;
        if (ord_valid !== 1'b1 || ord_side !== 1'b0) begin
            errors++;
            $display("FAIL limit_sell v=%b s=%b required 1/0", ord_valid, ord_side);
        end
        tick();
        exp_pos -= QTY;
        vectors++;
        if (position !== 8'sd15) begin
            errors++;
            $display("FAIL limit_after_sell pos=%0d required 15", position);
        end
        wait_idle();
    endtask

    task automatic test_both();
        decide(1'b1, 1'b1, 8'd33);
        vectors++;
        if ({ord_valid, reject, drop, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL both_set v=%b r=%b d=%b b=%b required 0000",
                     ord_valid, reject, drop, busy);
        end
        decide(1'b0, 1'b0, 8'd34);
        vectors++;
        if ({ord_valid, reject, drop, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL none_set v=%b r=%b d=%b b=%b required 0000",
                     ord_valid, reject, drop, busy);
        end
    endtask

    task automatic test_halt();
        ord_ready = 1'b0;
        decide(1'b1, 1'b0, 8'd88);
        tick();
        halt = 1'b1;
        tick();
        vectors++;
        if (ord_valid !== 1'b0 || busy !== 1'b1 || position !== exp_pos[PW-1:0]) begin
            errors++;
            $display("FAIL halt_enter v=%b b=%b pos=%0d required 0/1/%0d",
                     ord_valid, busy, position, exp_pos);
        end
        ord_ready = 1'b1;
        tick();
        vectors++;
        if (ord_valid !== 1'b0 || position !== exp_pos[PW-1:0]) begin
            errors++;
            $display("FAIL halt_hold v=%b pos=%0d required 0/%0d",
                     ord_valid, position, exp_pos);
        end
        halt = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_release busy=%b required 0", busy);
        end
        decide(1'b1, 1'b0, 8'd89);
        vectors++;
        if (ord_valid !== 1'b1 || ord_price !== 8'd89) begin
            errors++;
            $display("FAIL halt_new_order v=%b p=%0d required 1/89", ord_valid, ord_price);
        end
        tick();
        exp_pos += QTY;
        wait_idle();
    endtask

`ifdef ORD_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        ord_ready = 1'b0;
        decide(1'b1, 1'b0, 8'd5);
        while (ord_valid && n < 100) begin
            n++;
            tick();
        end
        vectors++;
        if (n != TO || timeout !== 1'b1 || busy !== 1'b1 ||
            position !== exp_pos[PW-1:0]) begin
            errors++;
            $display("FAIL timeout_abort cycles=%0d t=%b b=%b pos=%0d required %0d/1/1/%0d",
                     n, timeout, busy, position, TO, exp_pos);
        end
        wait_idle();
        decide(1'b1, 1'b0, 8'd6);
        for (int i = 1; i < TO; i++) tick();
        vectors++;
        if (ord_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_last_cycle v=%b required 1", ord_valid);
        end
        ord_ready = 1'b1;
        tick();
        exp_pos += QTY;
        vectors++;
        if (position !== exp_pos[PW-1:0] || timeout !== 1'b0 || ord_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_accept pos=%0d t=%b v=%b required %0d/0/0",
                     position, timeout, ord_valid, exp_pos);
        end
        wait_idle();
    endtask
`endif

    task automatic test_random();
        int m_pos = exp_pos;
        int m_cool = 0;
        int m_cnt = 0;
        bit m_pend = 0, m_side = 0, m_halt = 0;
        logic [DW-1:0] m_price = '0;
        bit sv, b, s, h, rdy, idle, e_rej, e_drop, e_to, e_busy;
        logic [DW-1:0] p;
        for (int c = 0; c < 600; c++) begin
            sv  = ($urandom % 3) != 0;
            b   = (c < 300) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            s   = (c < 300) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            h   = ($urandom % 25) == 0;
            rdy = ($urandom % 4) != 0;
            p   = 8'($urandom);
            sig_valid = sv; buy_signal = b; sell_signal = s;
            halt = h; ord_ready = rdy; price = p;

            idle   = !m_pend && m_cool == 0 && !m_halt;
            e_drop = sv && !idle;
            e_rej  = 0;
            e_to   = 0;
            if (h) begin
                m_pend = 0; m_cool = 0; m_halt = 1;
            end else if (m_halt) begin
                m_halt = 0;
            end else if (m_pend) begin
                if (rdy) begin
                    m_pos += m_side ? QTY : -QTY;
                    m_pend = 0;
                    m_cool = COOL;
                end
`ifdef ORD_TIMEOUT_EN
                else if (m_cnt == TO) begin
                    m_pend = 0; m_cool = COOL; e_to = 1;
                end else begin
                    m_cnt++;
                end
`endif
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (sv && (b ^ s)) begin
                if (b ? (m_pos + QTY > MAXP) : (m_pos - QTY < -MAXP)) begin
                    e_rej = 1;
                end else begin
                    m_pend = 1; m_side = b; m_price = p; m_cnt = 1;
                end
            end
            e_busy = m_pend || m_cool > 0 || m_halt;

            tick();
            vectors++;
            if ({ord_valid, busy, reject, drop, timeout} !==
                {m_pend, e_busy, e_rej, e_drop, e_to} ||
                position !== m_pos[PW-1:0]) begin
                errors++;
                $display("FAIL random c=%0d got v%b b%b r%b d%b t%b pos%0d required v%b b%b r%b d%b t%b pos%0d",
                         c, ord_valid, busy, reject, drop, timeout, position,
                         m_pend, e_busy, e_rej, e_drop, e_to, m_pos);
            end
            if (m_pend) begin
                vectors++;
                if (ord_side !== m_side || ord_price !== m_price) begin
                    errors++;
                    $display("FAIL random_fields c=%0d side=%b price=%0d required %b/%0d",
                             c, ord_side, ord_price, m_side, m_price);
                end
            end
        end
        sig_valid = 0; buy_signal = 0; sell_signal = 0; halt = 0;
        exp_pos = m_pos;
    endtask

    initial begin
        test_reset();
        test_basic_buy();
        test_backpressure();
        test_limit();
        test_both();
        test_halt();
`ifdef ORD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
